lnrv_ilm_loader: RTL

LNRV_ILM_LOADER -- requirements
Module: lnrv_ilm_loader

---
 rtl/lnrv_loader_pkg.sv | 16 +
 rtl/lnrv_loader_asm.sv | 39 +++
 rtl/lnrv_ilm_loader.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/lnrv_loader_pkg.sv
// Shared definitions for the ILM loader: FSM state encodings and the
// default release delay.
package lnrv_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_VERIFY  = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5
  } loader_state_e;

  localparam int unsigned LNRV_RELEASE_DLY_DEF = 4;

endpackage

// File: rtl/lnrv_loader_asm.sv
// Byte-to-word assembler. Little-endian: the first byte accepted ends up in
// bits [7:0] once four bytes have been shifted in.
// Ports: clk, reset_n (async active-low), clr (restart at byte 0),
//        byte_vld/byte_data (accepted byte), word (assembled word),
//        word_vld (fourth byte accepted this cycle), byte_idx (next byte slot).
module lnrv_loader_asm
  import lnrv_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_vld,
  output logic [1:0]  byte_idx
);

  logic [1:0]  byte_idx_q;
  logic [31:0] word_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx_q <= '0;
      word_q     <= '0;
    end else if (clr) begin
      byte_idx_q <= '0;
    end else if (byte_vld) begin
      byte_idx_q <= byte_idx_q + 2'd1;
      // Shift right so byte 0 settles into the low lane after four bytes.
      word_q     <= {byte_data, word_q[31:8]};
    end
  end

  assign word     = word_q;
  assign word_vld = byte_vld && (byte_idx_q == 2'd3);
  assign byte_idx = byte_idx_q;

endmodule

// File: rtl/lnrv_ilm_loader.sv
// ILM loader: streams firmware bytes into the ILM RAM, optionally verifies
// them with a read-back checksum, then releases the core reset.
// Optional feature macro: LNRV_ILM_LOADER_VERIFY_EN (read-back checksum).
// Ports: clk, reset_n (async active-low); start/load_words (load request);
//        s_valid/s_data/s_ready (byte stream); cpu_ilm_* (core ILM request,
//        passed to RAM while idle); ram_* (ILM RAM port, 1-cycle read);
//        cpu_reset_n, busy, done, err (status).
//
// state      | meaning
// IDLE       | waiting for start, core held in reset
// COLLECT    | accepting stream bytes for the current word
// WRITE      | one-cycle RAM write of the assembled word
// VERIFY     | reading back all words and summing them
// RELEASE    | counting down before the core reset is released
// DONE       | load complete, core running, RAM owned by the core
module lnrv_ilm_loader
  import lnrv_loader_pkg::*;
#(
  parameter int unsigned P_ADDR_WIDTH  = 16,
  parameter int unsigned P_RELEASE_DLY = LNRV_RELEASE_DLY_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [P_ADDR_WIDTH:0]   load_words,
  input  logic                    s_valid,
  input  logic [7:0]              s_data,
  output logic                    s_ready,
  input  logic                    cpu_ilm_cs,
  input  logic                    cpu_ilm_we,
  input  logic [3:0]              cpu_ilm_wem,
  input  logic [P_ADDR_WIDTH-1:0] cpu_ilm_addr,
  input  logic [31:0]             cpu_ilm_wdata,
  output logic                    ram_cs,
  output logic                    ram_we,
  output logic [3:0]              ram_wem,
  output logic [P_ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]             ram_wdata,
  input  logic [31:0]             ram_rdata,
  output logic                    cpu_reset_n,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam logic [P_ADDR_WIDTH:0] WORDS_MAX = {1'b1, {P_ADDR_WIDTH{1'b0}}};
  localparam logic [P_ADDR_WIDTH:0] ONE       = {{P_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [7:0]            RLS_INIT  = 8'(P_RELEASE_DLY - 1);

  loader_state_e state_q, state_d;

  logic [P_ADDR_WIDTH:0]   words_q, word_idx_q, word_idx_nxt;
  logic [7:0]              rel_cnt_q;
  logic                    err_q, cpu_reset_n_q;
  logic                    start_idle, start_bad, start_ok;
  logic [31:0]             asm_word;
  logic                    asm_word_vld;
  logic [1:0]              asm_byte_idx;
  logic                    rd_issue, vrfy_last, vrfy_ok;
  logic [P_ADDR_WIDTH-1:0] rd_addr;
  logic                    ld_cs, ld_we;
  logic [3:0]              ld_wem;
  logic [P_ADDR_WIDTH-1:0] ld_addr;
  logic [31:0]             ld_wdata;

  assign start_idle   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign start_bad    = start_idle && (load_words > WORDS_MAX);
  assign start_ok     = start_idle && !start_bad;
  assign word_idx_nxt = word_idx_q + ONE;

  lnrv_loader_asm u_asm (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (start_ok),
    .byte_vld  (s_valid && s_ready),
    .byte_data (s_data),
    .word      (asm_word),
    .word_vld  (asm_word_vld),
    .byte_idx  (asm_byte_idx)
  );

`ifdef LNRV_ILM_LOADER_VERIFY_EN
  localparam loader_state_e ST_AFTER_WR = ST_VERIFY;

  logic [P_ADDR_WIDTH:0] rd_idx_q;
  logic                  rd_pend_q;
  logic [31:0]           wr_sum_q, rd_sum_q, rd_sum_fin;

  assign rd_issue   = (state_q == ST_VERIFY) && (rd_idx_q != words_q);
  assign rd_addr    = rd_idx_q[P_ADDR_WIDTH-1:0];
  // The read issued last cycle returns now, so fold it in before comparing.
  assign rd_sum_fin = rd_sum_q + (rd_pend_q ? ram_rdata : 32'h0);
  assign vrfy_last  = (state_q == ST_VERIFY) && !rd_issue;
  assign vrfy_ok    = (rd_sum_fin == wr_sum_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_idx_q  <= '0;
      rd_pend_q <= 1'b0;
      wr_sum_q  <= '0;
      rd_sum_q  <= '0;
    end else if (start_ok) begin
      rd_idx_q  <= '0;
      rd_pend_q <= 1'b0;
      wr_sum_q  <= '0;
      rd_sum_q  <= '0;
    end else begin
      if (state_q == ST_WRITE) wr_sum_q <= wr_sum_q + asm_word;
      rd_pend_q <= rd_issue;
      if (rd_issue)  rd_idx_q <= rd_idx_q + ONE;
      if (rd_pend_q) rd_sum_q <= rd_sum_fin;
    end
  end
`else
  localparam loader_state_e ST_AFTER_WR = ST_RELEASE;

  logic unused_rdata;
  assign unused_rdata = ^{ram_rdata, asm_byte_idx};
  assign rd_issue     = 1'b0;
  assign rd_addr      = '0;
  assign vrfy_last    = 1'b0;
  assign vrfy_ok      = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (load_words > WORDS_MAX)  state_d = ST_IDLE;
          else if (load_words == '0)   state_d = ST_RELEASE;
          else                         state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: if (asm_word_vld) state_d = ST_WRITE;
      ST_WRITE:   state_d = (word_idx_nxt == words_q) ? ST_AFTER_WR : ST_COLLECT;
      ST_VERIFY:  if (vrfy_last) state_d = vrfy_ok ? ST_RELEASE : ST_IDLE;
      ST_RELEASE: if (rel_cnt_q == 8'd0) state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_cs    = 1'b0;
    ld_we    = 1'b0;
    ld_wem   = 4'h0;
    ld_addr  = '0;
    ld_wdata = '0;
    s_ready  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      ST_WRITE: begin
        busy     = 1'b1;
        ld_cs    = 1'b1;
        ld_we    = 1'b1;
        ld_wem   = 4'hF;
        ld_addr  = word_idx_q[P_ADDR_WIDTH-1:0];
        ld_wdata = asm_word;
      end
      ST_VERIFY: begin
        busy    = 1'b1;
        ld_cs   = rd_issue;
        ld_addr = rd_addr;
      end
      ST_RELEASE: busy = 1'b1;
      ST_DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      words_q       <= '0;
      word_idx_q    <= '0;
      rel_cnt_q     <= '0;
      err_q         <= 1'b0;
      cpu_reset_n_q <= 1'b0;
    end else begin
      if (start_ok) begin
        words_q    <= load_words;
        word_idx_q <= '0;
      end else if (state_q == ST_WRITE) begin
        word_idx_q <= word_idx_nxt;
      end
      // Reloaded every cycle outside RELEASE so each entry starts a full count.
      rel_cnt_q <= (state_q == ST_RELEASE) ? rel_cnt_q - 8'd1 : RLS_INIT;
      if (start_bad)                  err_q <= 1'b1;
      else if (start_ok)              err_q <= 1'b0;
      else if (vrfy_last && !vrfy_ok) err_q <= 1'b1;
      // Core runs only while in DONE; leaving DONE for a reload re-asserts reset.
      cpu_reset_n_q <= (state_d == ST_DONE);
    end
  end

  assign err         = err_q;
  assign cpu_reset_n = cpu_reset_n_q;

  assign ram_cs    = busy ? ld_cs    : cpu_ilm_cs;
  assign ram_we    = busy ? ld_we    : cpu_ilm_we;
  assign ram_wem   = busy ? ld_wem   : cpu_ilm_wem;
  assign ram_addr  = busy ? ld_addr  : cpu_ilm_addr;
  assign ram_wdata = busy ? ld_wdata : cpu_ilm_wdata;

endmodule
